clk_div_bank: RTL and testbench
===============================

CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 SHALL have parameter NUM_CLOCKS, default 2: number of output clock channels (1..8).
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of half-period and phase fields.
REQ-003 SHALL have parameter LOCK_DELAY, default 8: cycles spent in WAIT_LOCK (>=1).
REQ-004 SHALL have parameter INIT_HALF, default {16'd8,16'd16}: packed NUM_CLOCKS*CNT_WIDTH power-up half-periods; ch0 in the LSBs.
REQ-005 SHALL have parameter INIT_PHASE, default all zeros: packed NUM_CLOCKS*CNT_WIDTH power-up phase offsets.
REQ-006 SHALL have port refclk  input  1  the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst  input  1  reset; asynchronous and active-low.
REQ-008 SHALL have port en  input  1  run enable; level-sensitive, sampled on refclk.
REQ-009 SHALL have port cfg_valid  input  1  configuration write request.
REQ-010 SHALL have port cfg_ready  output  1  configuration write can be accepted.
REQ-011 SHALL have port cfg_chan  input  3  target channel index.
REQ-012 SHALL have port cfg_half  input  CNT_WIDTH  new half-period H, in refclk cycles.
REQ-013 SHALL have port cfg_phase  input  CNT_WIDTH  new phase offset P, in refclk cycles.
REQ-014 SHALL have port cfg_err  output  1  one-cycle pulse when a write is rejected.
REQ-015 SHALL have port outclk  output  NUM_CLOCKS  divided clocks; all registered.
REQ-016 SHALL have port locked  output  1  high only while all channels run phase-aligned.

Function
REQ-017 SHALL implement states IDLE, WAIT_LOCK, RUN, RECONF.
REQ-018 IDLE -> WAIT_LOCK on an edge sampling en=1; any state -> IDLE on an edge sampling en=0 (en=0 has priority over cfg).
REQ-019 WAIT_LOCK SHALL last exactly LOCK_DELAY edges, then -> RUN; outclk all 0 and locked=0 in IDLE, WAIT_LOCK, RECONF.
REQ-020 On the edge entering RUN: locked->1, and every channel with P=0 drives outclk[i]=1 on that same edge.
REQ-021 In RUN, channel i with half H and phase P SHALL first rise P edges after RUN entry, then repeat high H cycles / low H cycles (period 2H); it stays low before its first rise.
REQ-022 cfg_ready SHALL be 1 in WAIT_LOCK and RUN, 0 in IDLE and RECONF; a write is accepted on an edge with cfg_valid=1 and cfg_ready=1.
REQ-023 Write SHALL be rejected (no state change, cfg_err=1 for one cycle on the next edge) if cfg_half=0, cfg_phase>=2*cfg_half, or cfg_chan>=NUM_CLOCKS.
REQ-024 Valid write SHALL, on the accepting edge, update the channel's H and P, force locked=0 and outclk=0, and enter RECONF for exactly one cycle, then WAIT_LOCK with the delay counter restarted.
REQ-025 A valid write during WAIT_LOCK SHALL restart the full LOCK_DELAY count.
REQ-026 Channel registers SHALL be retained across IDLE; all channels restart together from RUN entry, so relative phases are deterministic.
REQ-027 Phase/position arithmetic SHALL be done in CNT_WIDTH+1 bits; H=2^CNT_WIDTH-1 SHALL work without overflow.

Reset
REQ-028 rst=0 SHALL, asynchronously, force state=IDLE, outclk=0, locked=0, cfg_ready=0, cfg_err=0, and reload H/P from INIT_HALF/INIT_PHASE.
REQ-029 Reset asserted mid-RUN or mid-RECONF SHALL discard any pending write; after release, behaviour is identical to power-up.

Verification
REQ-030 Defaults, release rst, en=1 -> locked rises on the 9th edge sampling en=1; outclk[0] period 32 (16 high), outclk[1] period 16, both rise on that edge.
REQ-031 In RUN write cfg_chan=1, cfg_half=4, cfg_phase=2 -> locked 0 next edge, 1 RECONF + 8 WAIT_LOCK cycles, then locked=1; outclk[1] first rises 2 edges later, period 8; outclk[0] unchanged period 32.
REQ-032 In RUN write cfg_half=0 (or cfg_chan=5, or cfg_half=4/cfg_phase=8) -> cfg_err pulses exactly 1 cycle; locked stays 1; outclk waveforms undisturbed.
REQ-033 Drop en in RUN -> next edge IDLE, outclk=0, locked=0, cfg_ready=0; reassert en -> relock after 9 edges with last programmed H/P.
REQ-034 Assert rst asynchronously between edges while in RUN -> all outputs 0 immediately; after release and relock, INIT_HALF values restored (period 32/16).
REQ-035 Two valid writes 3 cycles apart during WAIT_LOCK -> locked rises 9 edges after the second write's accept edge (1 RECONF + 8), not the first's.

Source files
------------

// File: rtl/clk_div_bank.sv
// Bank of phase-aligned clock dividers driven from one reference clock.
// Channels are reprogrammed through a valid/ready port; every valid write forces a full relock.
module clk_div_bank #(
    parameter int NUM_CLOCKS = 2,
    parameter int CNT_WIDTH  = 16,
    parameter int LOCK_DELAY = 8,
    parameter logic [NUM_CLOCKS*CNT_WIDTH-1:0] INIT_HALF  = {16'd8, 16'd16},
    parameter logic [NUM_CLOCKS*CNT_WIDTH-1:0] INIT_PHASE = '0
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [2:0]            cfg_chan,
    input  logic [CNT_WIDTH-1:0]  cfg_half,
    input  logic [CNT_WIDTH-1:0]  cfg_phase,
    output logic                  cfg_err,
    output logic [NUM_CLOCKS-1:0] outclk,
    output logic                  locked
);

    typedef enum logic [1:0] {IDLE, WAIT_LOCK, RUN, RECONF} state_t;

    localparam int LW = $clog2(LOCK_DELAY + 1);

    state_t          state_q, state_d;
    logic [LW-1:0]   lock_cnt_q, lock_cnt_d;
    logic            cfg_err_q, cfg_err_d;
    logic            cfg_fire, cfg_bad, cfg_ok;

    // Phase is compared against 2H in one extra bit so H = 2^CNT_WIDTH-1 cannot wrap.
    assign cfg_fire  = en && cfg_valid && cfg_ready;
    assign cfg_bad   = (cfg_half == '0)
                    || ({1'b0, cfg_phase} >= {cfg_half, 1'b0})
                    || ({1'b0, cfg_chan} >= 4'(NUM_CLOCKS));
    assign cfg_ok    = cfg_fire && !cfg_bad;
    assign cfg_err_d = cfg_fire && cfg_bad;

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            lock_cnt_q <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = WAIT_LOCK;
                    lock_cnt_d = '0;
                end
                WAIT_LOCK: begin
                    if (cfg_ok) begin
                        state_d = RECONF;
                    end else if (lock_cnt_q == LW'(LOCK_DELAY - 1)) begin
                        state_d = RUN;
                    end else begin
                        lock_cnt_d = lock_cnt_q + LW'(1);
                    end
                end
                RUN: begin
                    if (cfg_ok) state_d = RECONF;
                end
                RECONF: begin
                    state_d    = WAIT_LOCK;
                    lock_cnt_d = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cfg_ready = (state_q == WAIT_LOCK) || (state_q == RUN);
        locked    = (state_q == RUN);
        cfg_err   = cfg_err_q;
    end

    for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_chan
        logic [CNT_WIDTH-1:0] half_q, phase_q;
        logic [CNT_WIDTH:0]   cnt_q, cnt_d, cnt_inc, period;
        logic                 started_q, started_d;
        logic                 out_q, out_d;

        assign cnt_inc   = cnt_q + {{CNT_WIDTH{1'b0}}, 1'b1};
        assign period    = {half_q, 1'b0};
        assign outclk[i] = out_q;

        always_ff @(posedge refclk or negedge rst) begin
            if (!rst) begin
                half_q  <= INIT_HALF[i*CNT_WIDTH +: CNT_WIDTH];
                phase_q <= INIT_PHASE[i*CNT_WIDTH +: CNT_WIDTH];
            end else if (cfg_ok && (cfg_chan == 3'(i))) begin
                half_q  <= cfg_half;
                phase_q <= cfg_phase;
            end
        end

        // Before the first rise cnt counts edges since RUN entry; afterwards it is the
        // position inside the 2H period, with the first H positions high.
        always_comb begin
            cnt_d     = cnt_q;
            started_d = started_q;
            out_d     = 1'b0;
            if (state_d == RUN) begin
                if (state_q != RUN) begin
                    started_d = (phase_q == '0);
                    cnt_d     = '0;
                    out_d     = (phase_q == '0);
                end else if (!started_q) begin
                    if (cnt_inc == {1'b0, phase_q}) begin
                        started_d = 1'b1;
                        cnt_d     = '0;
                        out_d     = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    cnt_d = (cnt_inc == period) ? '0 : cnt_inc;
                    out_d = (cnt_d < {1'b0, half_q});
                end
            end
        end

        always_ff @(posedge refclk or negedge rst) begin
            if (!rst) begin
                cnt_q     <= '0;
                started_q <= 1'b0;
                out_q     <= 1'b0;
            end else begin
                cnt_q     <= cnt_d;
                started_q <= started_d;
                out_q     <= out_d;
            end
        end
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: directed relock/reconfigure scenarios followed by
// randomized traffic, all compared every cycle against an edge-count model of the divider bank.
module tb_clk_div_bank;

    localparam int NUM_CLOCKS = 2;
    localparam int CNT_WIDTH  = 16;
    localparam int LOCK_DELAY = 8;

    localparam int M_IDLE   = 0;
    localparam int M_WAIT   = 1;
    localparam int M_RUN    = 2;
    localparam int M_RECONF = 3;

    logic                  refclk = 1'b0;
    logic                  rst = 1'b1;
    logic                  en = 1'b0;
    logic                  cfg_valid = 1'b0;
    logic                  cfg_ready;
    logic [2:0]            cfg_chan = '0;
    logic [CNT_WIDTH-1:0]  cfg_half = '0;
    logic [CNT_WIDTH-1:0]  cfg_phase = '0;
    logic                  cfg_err;
    logic [NUM_CLOCKS-1:0] outclk;
    logic                  locked;

    int passCount = 0;
    int checkCount = 0;

    clk_div_bank #(
        .NUM_CLOCKS(NUM_CLOCKS),
        .CNT_WIDTH (CNT_WIDTH),
        .LOCK_DELAY(LOCK_DELAY)
    ) dut (
        .refclk   (refclk),
        .rst      (rst),
        .en       (en),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_chan (cfg_chan),
        .cfg_half (cfg_half),
        .cfg_phase(cfg_phase),
        .cfg_err  (cfg_err),
        .outclk   (outclk),
        .locked   (locked)
    );

    always #5 refclk = ~refclk;

    // Reference model: state of the bank expressed as edge counts since WAIT_LOCK / RUN entry.
    int     mMode = M_IDLE;
    int     mWaitEdges = 0;
    longint mRunT = 0;
    int     mHalf[NUM_CLOCKS];
    int     mPhase[NUM_CLOCKS];
    bit     mErr = 1'b0;

    function automatic void modelReset();
        mMode      = M_IDLE;
        mWaitEdges = 0;
        mRunT      = 0;
        mErr       = 1'b0;
        mHalf[0]   = 16;
        mHalf[1]   = 8;
        mPhase[0]  = 0;
        mPhase[1]  = 0;
    endfunction

    function automatic bit modelChanOut(int i);
        longint h, p;
        h = longint'(mHalf[i]);
        p = longint'(mPhase[i]);
        if (mMode != M_RUN || mRunT < p) return 1'b0;
        return ((mRunT - p) % (2 * h)) < h;
    endfunction

    function automatic logic [NUM_CLOCKS-1:0] modelOutclk();
        logic [NUM_CLOCKS-1:0] v;
        for (int i = 0; i < NUM_CLOCKS; i++) v[i] = modelChanOut(i);
        return v;
    endfunction

    always @(posedge refclk or negedge rst) begin
        if (!rst) begin
            modelReset();
        end else begin
            bit accepted, bad;
            mErr     = 1'b0;
            accepted = 1'b0;
            bad = (cfg_half == 0) || (int'(cfg_phase) >= 2 * int'(cfg_half))
               || (int'(cfg_chan) >= NUM_CLOCKS);
            if (!en) begin
                mMode = M_IDLE;
            end else if (mMode == M_IDLE) begin
                mMode = M_WAIT;
                mWaitEdges = 0;
            end else if (mMode == M_RECONF) begin
                mMode = M_WAIT;
                mWaitEdges = 0;
            end else begin
                if (cfg_valid) begin
                    if (bad) begin
                        mErr = 1'b1;
                    end else begin
                        mHalf[cfg_chan]  = int'(cfg_half);
                        mPhase[cfg_chan] = int'(cfg_phase);
                        mMode = M_RECONF;
                        accepted = 1'b1;
                    end
                end
                if (!accepted) begin
                    if (mMode == M_WAIT) begin
                        mWaitEdges++;
                        if (mWaitEdges == LOCK_DELAY) begin
                            mMode = M_RUN;
                            mRunT = 0;
                        end
                    end else begin
                        mRunT++;
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge refclk) begin
        checkOutput("outclk",    32'(outclk),    32'(modelOutclk()));
        checkOutput("locked",    32'(locked),    32'(mMode == M_RUN));
        checkOutput("cfg_ready", 32'(cfg_ready), 32'((mMode == M_WAIT) || (mMode == M_RUN)));
        checkOutput("cfg_err",   32'(cfg_err),   32'(mErr));
    end

    task automatic tick();
        @(posedge refclk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] ch,
                                 input logic [CNT_WIDTH-1:0] h, input logic [CNT_WIDTH-1:0] p);
        cfg_valid = v;
        cfg_chan  = ch;
        cfg_half  = h;
        cfg_phase = p;
    endtask

    task automatic waitLocked(input string name, input int expected);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!locked && n < 50);
        checkOutput(name, 32'(n), 32'(expected));
    endtask

    task automatic badWrite(input string name, input logic [2:0] ch,
                            input logic [CNT_WIDTH-1:0] h, input logic [CNT_WIDTH-1:0] p);
        applyStimulus(1'b1, ch, h, p);
        tick();
        applyStimulus(1'b0, 3'd0, '0, '0);
        checkOutput({name, "_err"}, 32'(cfg_err), 32'd1);
        checkOutput({name, "_locked"}, 32'(locked), 32'd1);
        tick();
        checkOutput({name, "_errclr"}, 32'(cfg_err), 32'd0);
    endtask

    initial begin
        #1 rst = 1'b0;
        ticks(3);
        checkOutput("rst_outclk", 32'(outclk), 32'd0);
        checkOutput("rst_locked", 32'(locked), 32'd0);
        checkOutput("rst_ready",  32'(cfg_ready), 32'd0);

        // Power-up lock with default divisors (ch0 H=16, ch1 H=8).
        rst = 1'b1;
        en  = 1'b1;
        waitLocked("lock_edges", 9);
        checkOutput("entry_out", 32'(outclk), 32'b11);
        ticks(8);
        checkOutput("t8_out", 32'(outclk), 32'b01);
        ticks(8);
        checkOutput("t16_out", 32'(outclk), 32'b10);

        badWrite("half0", 3'd0, 16'd0, 16'd0);
        badWrite("chan5", 3'd5, 16'd4, 16'd0);
        badWrite("phase8", 3'd1, 16'd4, 16'd8);

        // Reprogram ch1 to H=4 P=2 while running.
        applyStimulus(1'b1, 3'd1, 16'd4, 16'd2);
        tick();
        applyStimulus(1'b0, 3'd0, '0, '0);
        checkOutput("reconf_locked", 32'(locked), 32'd0);
        waitLocked("reconf_lock_edges", 9);
        checkOutput("reconf_entry_out", 32'(outclk), 32'b01);
        ticks(2);
        checkOutput("reconf_t2_out", 32'(outclk), 32'b11);
        ticks(12);

        // Drop and restore enable; programmed values survive IDLE.
        en = 1'b0;
        tick();
        checkOutput("idle_locked", 32'(locked), 32'd0);
        checkOutput("idle_ready",  32'(cfg_ready), 32'd0);
        checkOutput("idle_outclk", 32'(outclk), 32'd0);
        en = 1'b1;
        waitLocked("relock_edges", 9);
        checkOutput("relock_out", 32'(outclk), 32'b01);

        // Two writes three cycles apart during WAIT_LOCK; only the second sets the lock time.
        en = 1'b0;
        tick();
        en = 1'b1;
        tick();
        applyStimulus(1'b1, 3'd0, 16'd3, 16'd5);
        tick();
        applyStimulus(1'b0, 3'd0, '0, '0);
        ticks(2);
        applyStimulus(1'b1, 3'd1, 16'd5, 16'd0);
        tick();
        applyStimulus(1'b0, 3'd0, '0, '0);
        waitLocked("double_write_lock", 9);
        checkOutput("double_write_out", 32'(outclk), 32'b10);
        ticks(7);

        // Asynchronous reset between edges while running restores the power-up divisors.
        #1 rst = 1'b0;
        #1;
        checkOutput("async_outclk", 32'(outclk), 32'd0);
        checkOutput("async_locked", 32'(locked), 32'd0);
        checkOutput("async_ready",  32'(cfg_ready), 32'd0);
        tick();
        rst = 1'b1;
        waitLocked("post_rst_lock", 9);
        ticks(8);
        checkOutput("post_rst_t8", 32'(outclk), 32'b01);
        ticks(8);
        checkOutput("post_rst_t16", 32'(outclk), 32'b10);

        // Randomized traffic, including occasional asynchronous resets.
        for (int c = 0; c < 4000; c++) begin
            int r;
            logic [CNT_WIDTH-1:0] h;
            en = ($urandom_range(63) != 0);
            r  = int'($urandom_range(9));
            if (r == 0)      h = '0;
            else if (r == 1) h = 16'hFFFF;
            else             h = CNT_WIDTH'($urandom_range(1, 10));
            applyStimulus(($urandom_range(15) == 0), 3'($urandom_range(0, 3)), h,
                          CNT_WIDTH'($urandom_range(0, 2 * int'(h) + 1)));
            if ($urandom_range(399) == 0) begin
                #1 rst = 1'b0;
                tick();
                rst = 1'b1;
            end else begin
                tick();
            end
        end

        applyStimulus(1'b0, 3'd0, '0, '0);
        tick();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
